rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 131 +++++++++++++
 tb/tb_rr_arbiter4.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time; grant, sel, busy and timeout are all registered.
// A grant lands one edge after a request in IDLE, and every release is followed by at least one IDLE cycle.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] last,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            rel_abort;
  logic            rel_normal;
  logic            rel_forced;
  logic            rel_any;

  // Search ptr, ptr+1, ... modulo 4; the first set request wins.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // While BUSY, sel_q names the grantee, so only its req/last bits matter.
  assign rel_abort  = ~req[sel_q];
  assign rel_normal = last[sel_q];
  assign rel_forced = (hold_q == HOLD_LAST);
  assign rel_any    = rel_abort | rel_normal | rel_forced;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)   state_d = BUSY;
      BUSY:    if (rel_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          ptr_d   = winner + 2'd1;
          hold_d  = '0;
          busy_d  = 1'b1;
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      BUSY: begin
        if (rel_any) begin
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          // A timeout is reported only when nothing else explains the release.
          timeout_d = rel_forced & ~rel_abort & ~rel_normal;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a MAX_HOLD=4 instance for most scenarios plus a default instance for the long hold.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;

  logic [3:0] g4, g16;
  logic [1:0] s4, s16;
  logic       b4, b16;
  logic       t4, t16;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .grant(g4), .sel(s4), .busy(b4), .timeout(t4)
  );

  rr_arbiter4 dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .grant(g16), .sel(s16), .busy(b16), .timeout(t16)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vectors are {grant, sel, busy, timeout}.
  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0; req = 4'b1111; last = 4'b0000;
    tick(); tick();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL reset_dut4 got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    n_tests++;
    if ({g16, s16, b16, t16} !== exp) begin
      n_fail++; $display("FAIL reset_dut16 got=%b want=%b", {g16, s16, b16, t16}, exp);
    end
    req = 4'b0000; rst_n = 1'b1;
    tick();
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL idle_no_req got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
  endtask

  task automatic test_rr_sequence();
    logic [7:0] exp;
    logic [3:0] oh;
    logic [1:0] k2;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      k2 = 2'(k % 4);
      oh = 4'b0001 << k2;
      last = 4'b0000;
      tick();
      exp = {oh, k2, 1'b1, 1'b0};
      n_tests++;
      if ({g4, s4, b4, t4} !== exp) begin
        n_fail++; $display("FAIL rr_grant_%0d got=%b want=%b", k, {g4, s4, b4, t4}, exp);
      end
      last = 4'b1111;
      tick();
      exp = {4'b0000, k2, 1'b0, 1'b0};
      n_tests++;
      if ({g4, s4, b4, t4} !== exp) begin
        n_fail++; $display("FAIL rr_idle_%0d got=%b want=%b", k, {g4, s4, b4, t4}, exp);
      end
    end
    req = 4'b0000; last = 4'b0000;
    tick();
  endtask

  // Entered with ptr = 1; leaves ptr = 2.
  task automatic test_abort_and_ignore();
    logic [7:0] exp;
    req = 4'b0100; last = 4'b0000;
    tick();
    exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL abort_grant2 got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    req = 4'b0010;
    tick();
    exp = {4'b0000, 2'd2, 1'b0, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL abort_release got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    tick();
    exp = {4'b0010, 2'd1, 1'b1, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL abort_regrant1 got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    for (int c = 0; c < 3; c++) begin
      req  = (c % 2 == 0) ? 4'b0011 : 4'b0010;
      last = (c % 2 == 0) ? 4'b1000 : 4'b0000;
      tick();
      n_tests++;
      if ({g4, s4, b4, t4} !== exp) begin
        n_fail++; $display("FAIL ignore_others_%0d got=%b want=%b", c, {g4, s4, b4, t4}, exp);
      end
    end
    req = 4'b0010; last = 4'b0000;
    tick();
    exp = {4'b0000, 2'd1, 1'b0, 1'b1};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL ignore_hold_timeout got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    req = 4'b0000;
    tick(); tick();
    exp = {4'b0000, 2'd1, 1'b0, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL idle_sel_held got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
  endtask

  // Entered with ptr = 2; leaves ptr = 1.
  task automatic test_timeout();
    logic [7:0] busy_v;
    logic [7:0] exp;
    busy_v = {4'b0001, 2'd0, 1'b1, 1'b0};
    req = 4'b0001; last = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if ({g4, s4, b4, t4} !== busy_v) begin
        n_fail++; $display("FAIL timeout_busy_%0d got=%b want=%b", c, {g4, s4, b4, t4}, busy_v);
      end
    end
    tick();
    exp = {4'b0000, 2'd0, 1'b0, 1'b1};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL timeout_pulse got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    tick();
    n_tests++;
    if ({g4, s4, b4, t4} !== busy_v) begin
      n_fail++; $display("FAIL timeout_regrant got=%b want=%b", {g4, s4, b4, t4}, busy_v);
    end
  endtask

  task automatic test_forced_and_last();
    logic [7:0] exp;
    exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({g4, s4, b4, t4} !== exp) begin
        n_fail++; $display("FAIL coincide_busy_%0d got=%b want=%b", c, {g4, s4, b4, t4}, exp);
      end
    end
    last = 4'b0001;
    tick();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL coincide_no_timeout got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    req = 4'b0000; last = 4'b0000;
    tick();
  endtask

  // Entered with ptr = 1.
  task automatic test_reset_mid_grant();
    logic [7:0] exp;
    req = 4'b1000;
    tick();
    exp = {4'b1000, 2'd3, 1'b1, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL rst_grant3 got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    rst_n = 1'b0;
    tick();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL rst_mid_grant got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    rst_n = 1'b1; req = 4'b1001;
    tick();
    exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL rst_then_1001 got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    req = 4'b0000;
    tick();
    // Grant 1 moves ptr to 2; after reset ptr 0 must pick 1 over 2.
    req = 4'b0010;
    tick();
    rst_n = 1'b0; req = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    exp = {4'b0010, 2'd1, 1'b1, 1'b0};
    n_tests++;
    if ({g4, s4, b4, t4} !== exp) begin
      n_fail++; $display("FAIL rst_ptr_zero got=%b want=%b", {g4, s4, b4, t4}, exp);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_default_hold();
    logic [7:0] exp;
    int busy_ok;
    busy_ok = 0;
    req = 4'b0001; last = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (b16 === 1'b1 && g16 === 4'b0001) busy_ok++;
    end
    n_tests++;
    if (busy_ok != 16) begin
      n_fail++; $display("FAIL default_hold_busy got=%0d cycles want=16", busy_ok);
    end
    tick();
    exp = {4'b0000, 2'd0, 1'b0, 1'b1};
    n_tests++;
    if ({g16, s16, b16, t16} !== exp) begin
      n_fail++; $display("FAIL default_hold_timeout got=%b want=%b", {g16, s16, b16, t16}, exp);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    last  = 4'b0000;
    test_reset();
    test_rr_sequence();
    test_abort_and_ignore();
    test_timeout();
    test_forced_and_last();
    test_reset_mid_grant();
    test_default_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
